// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the pipelined RV32I core. It captures the
// decoder's control bundle and the ID-stage operands into the EX stage. It
// also detects load-use hazards and turns them into a one-cycle bubble plus an
// upstream stall. Branch/jump flushes are squashed into bubbles as well. A
// saturating counter tracks how many load-use bubbles have been inserted.
//
// Optional feature macro: LOAD_USE_DETECT_EN
//   defined   : hazard detection active, stall_o and bubble_cnt live
//   undefined : no hazard detection; stall_o = 0, bubble_cnt = 0
//               (software schedules a NOP after a load whose result is
//               consumed by the next instruction)
//
// Parameters
//   XLEN  : datapath width
//   CNT_W : width of the bubble counter
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   id_valid                  : ID slot holds a real instruction
//   id_regwrite .. id_jalr    : single-bit decoder controls
//   id_aluop[4:0]             : ALU operation (0 = nop)
//   id_wdsel[1:0]             : writeback select
//   id_dmtype[2:0]            : memory access type
//   id_use_rs1, id_use_rs2    : instruction actually reads rs1 / rs2
//   id_rs1, id_rs2, id_rd     : register indices
//   id_pc .. id_imm           : XLEN-wide operands
//   flush                     : EX redirect, squash the ID instruction
//   mem_stall                 : global hold from data memory
//   ex_*                      : registered copies of the id_* bundle
//   stall_o                   : hold PC and IF/ID this cycle
//   bubble_cnt                : load-use bubbles inserted since reset
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic             id_regwrite,
    input  logic             id_memwrite,
    input  logic             id_memread,
    input  logic             id_alusrc,
    input  logic             id_sbtype,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic [4:0]       id_aluop,
    input  logic [1:0]       id_wdsel,
    input  logic [2:0]       id_dmtype,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,

    input  logic             flush,
    input  logic             mem_stall,

    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memwrite,
    output logic             ex_memread,
    output logic             ex_alusrc,
    output logic             ex_sbtype,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic [4:0]       ex_aluop,
    output logic [1:0]       ex_wdsel,
    output logic [2:0]       ex_dmtype,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,

    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Everything that travels from ID to EX, kept as one word so that a
    // bubble is simply "all zero" and a hold is simply "keep the word".
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            memread;
        logic            alusrc;
        logic            sbtype;
        logic            jal;
        logic            jalr;
        logic [4:0]      aluop;
        logic [1:0]      wdsel;
        logic [2:0]      dmtype;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } bundle_t;

    bundle_t id_bundle;
    bundle_t ex_q;
    bundle_t ex_d;
    logic    lu;

    assign id_bundle = {
        id_valid, id_regwrite, id_memwrite, id_memread,
        id_alusrc, id_sbtype, id_jal, id_jalr,
        id_aluop, id_wdsel, id_dmtype,
        id_rs1, id_rs2, id_rd,
        id_pc, id_rs1_data, id_rs2_data, id_imm
    };

    // -------------------------------------------------------------------------
    // Load-use hazard detection
    // -------------------------------------------------------------------------
`ifdef LOAD_USE_DETECT_EN
    logic rs1_hit;
    logic rs2_hit;
    logic ex_is_load;

    // A load targeting x0 never produces a value, so it cannot cause a stall.
    assign ex_is_load = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0);
    assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_q.rd);
    assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_q.rd);
    assign lu         = ex_is_load & (rs1_hit | rs2_hit) & id_valid;

    // A flush kills the dependent instruction anyway, and mem_stall freezes
    // the whole pipe, so neither needs an extra upstream hold.
    assign stall_o    = lu & ~flush & ~mem_stall;
`else
    // Operand-use flags only matter to the hazard logic.
    logic unused_use_flags;
    assign unused_use_flags = id_use_rs1 ^ id_use_rs2;

    assign lu      = 1'b0;
    assign stall_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Pipeline register: hold > flush bubble > load-use bubble > advance
    // -------------------------------------------------------------------------
    always_comb begin
        ex_d = ex_q;
        if (mem_stall) begin
            ex_d = ex_q;
        end else if (flush) begin
            ex_d = '0;
        end else if (lu) begin
            ex_d = '0;
        end else begin
            ex_d = id_bundle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // -------------------------------------------------------------------------
    // Bubble counter (load-use bubbles only, saturating)
    // -------------------------------------------------------------------------
`ifdef LOAD_USE_DETECT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        // Same qualification as the load-use bubble itself: a flush or a
        // memory hold in the same cycle means no bubble was inserted.
        if (!mem_stall && !flush && lu && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

    // -------------------------------------------------------------------------
    // Output unpacking
    // -------------------------------------------------------------------------
    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_sbtype   = ex_q.sbtype;
    assign ex_jal      = ex_q.jal;
    assign ex_jalr     = ex_q.jalr;
    assign ex_aluop    = ex_q.aluop;
    assign ex_wdsel    = ex_q.wdsel;
    assign ex_dmtype   = ex_q.dmtype;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A transaction-level model holds the
// expected EX contents and bubble count and applies the stage's priority rules
// (reset, hold, flush, load-use, advance) once per clock edge. Directed
// scenarios plus a randomized run compare the DUT against that model.
// The DUT is built with CNT_W = 4 so counter saturation is reachable.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;
`ifdef LOAD_USE_DETECT_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        memread;
        logic        alusrc;
        logic        sbtype;
        logic        jal;
        logic        jalr;
        logic [4:0]  aluop;
        logic [1:0]  wdsel;
        logic [2:0]  dmtype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } bun_t;

    logic clk = 1'b0;
    logic rst;
    bun_t id_b;
    logic id_use_rs1, id_use_rs2;
    logic flush, mem_stall;

    logic             ex_valid, ex_regwrite, ex_memwrite, ex_memread;
    logic             ex_alusrc, ex_sbtype, ex_jal, ex_jalr;
    logic [4:0]       ex_aluop;
    logic [1:0]       ex_wdsel;
    logic [2:0]       ex_dmtype;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic             stall_o;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state
    bun_t m_ex;
    int   m_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_b.valid),
        .id_regwrite(id_b.regwrite),
        .id_memwrite(id_b.memwrite),
        .id_memread (id_b.memread),
        .id_alusrc  (id_b.alusrc),
        .id_sbtype  (id_b.sbtype),
        .id_jal     (id_b.jal),
        .id_jalr    (id_b.jalr),
        .id_aluop   (id_b.aluop),
        .id_wdsel   (id_b.wdsel),
        .id_dmtype  (id_b.dmtype),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rs1     (id_b.rs1),
        .id_rs2     (id_b.rs2),
        .id_rd      (id_b.rd),
        .id_pc      (id_b.pc),
        .id_rs1_data(id_b.rs1_data),
        .id_rs2_data(id_b.rs2_data),
        .id_imm     (id_b.imm),
        .flush      (flush),
        .mem_stall  (mem_stall),
        .ex_valid   (ex_valid),
        .ex_regwrite(ex_regwrite),
        .ex_memwrite(ex_memwrite),
        .ex_memread (ex_memread),
        .ex_alusrc  (ex_alusrc),
        .ex_sbtype  (ex_sbtype),
        .ex_jal     (ex_jal),
        .ex_jalr    (ex_jalr),
        .ex_aluop   (ex_aluop),
        .ex_wdsel   (ex_wdsel),
        .ex_dmtype  (ex_dmtype),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_pc      (ex_pc),
        .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data),
        .ex_imm     (ex_imm),
        .stall_o    (stall_o),
        .bubble_cnt (bubble_cnt)
    );

    function automatic bun_t dut_ex();
        bun_t b;
        b.valid    = ex_valid;    b.regwrite = ex_regwrite;
        b.memwrite = ex_memwrite; b.memread  = ex_memread;
        b.alusrc   = ex_alusrc;   b.sbtype   = ex_sbtype;
        b.jal      = ex_jal;      b.jalr     = ex_jalr;
        b.aluop    = ex_aluop;    b.wdsel    = ex_wdsel;
        b.dmtype   = ex_dmtype;   b.rs1      = ex_rs1;
        b.rs2      = ex_rs2;      b.rd       = ex_rd;
        b.pc       = ex_pc;       b.rs1_data = ex_rs1_data;
        b.rs2_data = ex_rs2_data; b.imm      = ex_imm;
        return b;
    endfunction

    function automatic bun_t rand_bun();
        bun_t b;
        b.valid    = 1'($urandom_range(0, 3) != 0);
        b.regwrite = 1'($urandom);   b.memwrite = 1'($urandom);
        b.memread  = 1'($urandom);   b.alusrc   = 1'($urandom);
        b.sbtype   = 1'($urandom);   b.jal      = 1'($urandom);
        b.jalr     = 1'($urandom);   b.aluop    = 5'($urandom);
        b.wdsel    = 2'($urandom);   b.dmtype   = 3'($urandom);
        b.rs1      = 5'($urandom_range(0, 3));
        b.rs2      = 5'($urandom_range(0, 3));
        b.rd       = 5'($urandom_range(0, 3));
        b.pc       = $urandom;       b.rs1_data = $urandom;
        b.rs2_data = $urandom;       b.imm      = $urandom;
        return b;
    endfunction

    function automatic bun_t mk_load(input logic [4:0] rd, input logic [4:0] rs1);
        bun_t b = '0;
        b.valid = 1'b1; b.regwrite = 1'b1; b.memread = 1'b1; b.alusrc = 1'b1;
        b.aluop = 5'b00001; b.wdsel = 2'b01; b.dmtype = 3'b010;
        b.rd = rd; b.rs1 = rs1; b.pc = 32'h0000_0100; b.imm = 32'h4;
        return b;
    endfunction

    function automatic bun_t mk_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
        bun_t b = '0;
        b.valid = 1'b1; b.regwrite = 1'b1; b.aluop = 5'b00010;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.pc = 32'h0000_0104; b.rs1_data = 32'h1111_0000; b.rs2_data = 32'h0000_2222;
        return b;
    endfunction

    // Load-use rule evaluated against the model's view of EX.
    function automatic bit model_lu();
        return LU_EN && m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id_b.valid &&
               ((id_use_rs1 && id_b.rs1 == m_ex.rd) || (id_use_rs2 && id_b.rs2 == m_ex.rd));
    endfunction

    function automatic bit model_stall();
        return model_lu() && !flush && !mem_stall;
    endfunction

    // Advance one clock edge and apply the stage rules to the model.
    task automatic tick();
        bit lu;
        lu = model_lu();
        @(posedge clk);
        if (rst) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (mem_stall) begin
            m_ex = m_ex;
        end else if (flush) begin
            m_ex = '0;
        end else if (lu) begin
            m_ex = '0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_ex = id_b;
        end
        #1;
        cyc++;
        $display("txn %0d rst=%0b ms=%0b fl=%0b ex_valid=%0b ex_rd=%0d cnt=%0d",
                 cyc, rst, mem_stall, flush, ex_valid, ex_rd, bubble_cnt);
    endtask

    task automatic idle_inputs();
        id_b = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        flush = 1'b0; mem_stall = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        id_b = rand_bun(); id_b.valid = 1'b1;
        mem_stall = 1'b1; flush = 1'b0;
        tick();
        mem_stall = 1'b0;
        tick();
        checks++;
        if (dut_ex() !== bun_t'(0)) begin
            errors++;
            $display("FAIL reset_ex actual=%h required=%h", dut_ex(), bun_t'(0));
        end
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt actual=%0d required=0", bubble_cnt);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall actual=%0b required=0", stall_o);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_passthrough();
        id_b = '0;
        id_b.valid = 1'b1; id_b.regwrite = 1'b1; id_b.alusrc = 1'b1;
        id_b.rd = 5'd5; id_b.rs1 = 5'd1; id_b.imm = 32'h10; id_b.aluop = 5'b00011;
        id_b.pc = 32'h80; id_b.rs1_data = 32'h1234_5678;
        id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_stall actual=%0b required=0", stall_o);
        end
        tick();
        checks++;
        if (ex_rd !== 5'd5 || ex_imm !== 32'h10 || ex_aluop !== 5'b00011 || ex_regwrite !== 1'b1) begin
            errors++;
            $display("FAIL pass_addi actual rd=%0d imm=%h aluop=%b rw=%0b required rd=5 imm=10 aluop=00011 rw=1",
                     ex_rd, ex_imm, ex_aluop, ex_regwrite);
        end
        checks++;
        if (dut_ex() !== m_ex) begin
            errors++;
            $display("FAIL pass_bundle actual=%h required=%h", dut_ex(), m_ex);
        end
    endtask

    task automatic test_load_use();
        bun_t add_b;
        id_b = mk_load(5'd7, 5'd2); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        tick();
        add_b = mk_alu(5'd9, 5'd7, 5'd8);
        id_b = add_b; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (stall_o !== LU_EN) begin
            errors++;
            $display("FAIL lu_stall actual=%0b required=%0b", stall_o, LU_EN);
        end
        tick();
        checks++;
        if (dut_ex() !== (LU_EN ? bun_t'(0) : add_b)) begin
            errors++;
            $display("FAIL lu_bubble actual=%h required=%h", dut_ex(), LU_EN ? bun_t'(0) : add_b);
        end
        checks++;
        if (bubble_cnt !== (LU_EN ? 4'd1 : 4'd0)) begin
            errors++;
            $display("FAIL lu_cnt actual=%0d required=%0d", bubble_cnt, LU_EN ? 1 : 0);
        end
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_drop actual=%0b required=0", stall_o);
        end
        tick();
        checks++;
        if (dut_ex() !== add_b) begin
            errors++;
            $display("FAIL lu_reload actual=%h required=%h", dut_ex(), add_b);
        end
    endtask

    task automatic test_x0_unused();
        bun_t b;
        id_b = mk_load(5'd0, 5'd1); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        tick();
        id_b = mk_alu(5'd4, 5'd0, 5'd0); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall actual=%0b required=0", stall_o);
        end
        id_b = mk_load(5'd3, 5'd1); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        tick();
        b = '0;
        b.valid = 1'b1; b.regwrite = 1'b1; b.alusrc = 1'b1; b.aluop = 5'b00100;
        b.rd = 5'd6; b.rs1 = 5'd3; b.rs2 = 5'd3; b.imm = 32'h1234_5000;
        id_b = b; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL unused_stall actual=%0b required=0", stall_o);
        end
        tick();
        checks++;
        if (dut_ex() !== b) begin
            errors++;
            $display("FAIL unused_latch actual=%h required=%h", dut_ex(), b);
        end
    endtask

    task automatic test_flush_vs_hazard();
        int cnt_before;
        id_b = mk_load(5'd9, 5'd1); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        tick();
        cnt_before = m_cnt;
        id_b = mk_alu(5'd10, 5'd2, 5'd9); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall actual=%0b required=0", stall_o);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (dut_ex() !== bun_t'(0)) begin
            errors++;
            $display("FAIL flush_bubble actual=%h required=0", dut_ex());
        end
        checks++;
        if (int'(bubble_cnt) != cnt_before) begin
            errors++;
            $display("FAIL flush_cnt actual=%0d required=%0d", bubble_cnt, cnt_before);
        end
    endtask

    task automatic test_mem_stall();
        bun_t sw_b;
        sw_b = '0;
        sw_b.valid = 1'b1; sw_b.memwrite = 1'b1; sw_b.alusrc = 1'b1; sw_b.aluop = 5'b00001;
        sw_b.dmtype = 3'b010; sw_b.rs1 = 5'd2; sw_b.rs2 = 5'd11;
        sw_b.rs2_data = 32'hDEADBEEF; sw_b.imm = 32'h8; sw_b.pc = 32'h200;
        id_b = sw_b; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_stall = 1'b1; flush = 1'b1;
            id_b = rand_bun();
            tick();
            checks++;
            if (dut_ex() !== sw_b) begin
                errors++;
                $display("FAIL mstall_hold%0d actual=%h required=%h", i, dut_ex(), sw_b);
            end
        end
        mem_stall = 1'b0;
        tick();
        flush = 1'b0;
        checks++;
        if (dut_ex() !== bun_t'(0)) begin
            errors++;
            $display("FAIL mstall_release actual=%h required=0", dut_ex());
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            id_b = mk_load(5'((k % 31) + 1), 5'd1); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
            tick();
            id_b = mk_alu(5'd20, 5'((k % 31) + 1), 5'd0); id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
            tick();
            exp_cnt = LU_EN ? ((k < CNT_MAX) ? k : CNT_MAX) : 0;
            checks++;
            if (int'(bubble_cnt) != exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt%0d actual=%0d required=%0d", k, bubble_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            mem_stall  = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            id_b       = rand_bun();
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            #1;
            checks++;
            if (stall_o !== model_stall()) begin
                errors++;
                $display("FAIL rnd_stall%0d actual=%0b required=%0b", i, stall_o, model_stall());
            end
            tick();
            checks++;
            if (dut_ex() !== m_ex) begin
                errors++;
                $display("FAIL rnd_ex%0d actual=%h required=%h", i, dut_ex(), m_ex);
            end
            checks++;
            if (int'(bubble_cnt) != m_cnt) begin
                errors++;
                $display("FAIL rnd_cnt%0d actual=%0d required=%0d", i, bubble_cnt, m_cnt);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        m_ex  = '0;
        m_cnt = 0;
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0_unused();
        test_flush_vs_hazard();
        test_mem_stall();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined RV32I core, placed directly downstream of the instruction decoder. It latches the decoder's control bundle plus the ID-stage operands into the EX stage. It also detects load-use hazards, inserts bubbles on them and on branch/jump flushes, and counts inserted bubbles for performance measurement.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_regwrite, id_memwrite, id_memread, id_alusrc, id_sbtype, id_jal, id_jalr  in  1 each  decoder controls
- id_aluop  in  5  ALU operation (5'b00000 = nop)
- id_wdsel  in  2  writeback select
- id_dmtype  in  3  memory access type
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands
- flush  in  1  EX-stage redirect (taken branch/jal/jalr); squash ID instruction
- mem_stall  in  1  global hold from data memory
- ex_*  out  matching widths  registered copies of every id_* input above except id_use_rs1/id_use_rs2 (ex_valid, ex_regwrite, ..., ex_imm)
- stall_o  out  1  hold PC and IF/ID register this cycle
- bubble_cnt  out  CNT_W  bubbles inserted since reset

## Operation
- Load-use hazard: lu = ex_valid & ex_memread & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & id_valid.
- stall_o = lu & ~flush & ~mem_stall (combinational).
- Per-edge update, priority highest first:
  1. rst: all ex_* cleared to 0; bubble_cnt = 0.
  2. mem_stall: all ex_* and bubble_cnt hold.
  3. flush: all ex_* cleared to 0 (bubble); bubble_cnt unchanged.
  4. lu: all ex_* cleared to 0 (bubble); bubble_cnt += 1, saturating at all-ones.
  5. otherwise: ex_* <= id_*.
- Bubble = every ex_* field zero, so ex_aluop = nop and all write/read enables are low.
- flush is not latched. While mem_stall is high the EX instruction is frozen, so the source keeps flush asserted until it is accepted.
- After a load-use bubble, ex_memread = 0, so lu cannot repeat. Each load-use costs exactly one bubble.
- The rd = x0 check prevents spurious stalls on loads to x0.

## Timing
- Latency: one cycle, ID inputs to ex_* outputs.
- stall_o is valid in the same cycle as the ID inputs. The upstream PC and IF/ID register must hold on stall_o, so the stalled instruction reappears next cycle and loads normally.
- Reset values: every ex_* = 0, bubble_cnt = 0, stall_o = 0 (because ex_valid = 0).
- Simultaneous events:
  - flush & lu: flush wins; no stall, no count.
  - mem_stall & anything: hold.
  - rst mid-stall: reset wins and stall_o drops on the next cycle.
- bubble_cnt wraps never; it saturates at all-ones.

## Configuration
- LOAD_USE_DETECT_EN defined: hazard logic, stall_o and bubble_cnt behave as above.
- LOAD_USE_DETECT_EN undefined:
  - lu is forced to 0, stall_o is tied to 0 and bubble_cnt is tied to 0.
  - Priority 4 is removed.
  - Software must place a NOP after every load whose result is consumed by the next instruction.

## Test plan
- Reset then pass-through: rst for 2 cycles, then send addi with id_rd=5, id_imm=0x10, id_aluop=5'b00011 -> next cycle ex_rd=5, ex_imm=0x10, ex_aluop=5'b00011, ex_regwrite=1; stall_o=0 throughout.
- Load-use stall: lw with rd=7 enters EX; ID holds add with rs1=7, id_use_rs1=1 -> stall_o=1 for 1 cycle; next edge all ex_* zero and bubble_cnt=1; following edge the add is latched and stall_o=0.
- x0 and unused operand:
  - lw with rd=0 followed by use of rs1=0 -> stall_o=0.
  - lw with rd=3 followed by lui (id_use_rs1=0, id_use_rs2=0, id_rs1 field=3) -> stall_o=0.
- Flush vs hazard: lu condition present and flush=1 in the same cycle -> stall_o=0; next edge ex_* zero; bubble_cnt unchanged.
- mem_stall hold: ex holds sw (ex_memwrite=1, ex_rs2_data=0xDEADBEEF); mem_stall=1 for 3 cycles with flush=1 and changing id_* -> ex_* unchanged for all 3 cycles; first edge after mem_stall falls clears ex_*.
- Counter saturation: with CNT_W=4, force 17 load-use bubbles -> bubble_cnt reads 15 after the 15th bubble and stays 15.
